// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings (also used by the ALU decoder) and the default operand width.
package seq_mult_unit_pkg;

   localparam int MULT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2
   } state_e;

endpackage

// File: rtl/seq_mult_unit_mag_conv.sv
// Combinational conditional two's complement negate. Used to take operand
// magnitudes on the way in and to restore the product sign on the way out.
module mag_conv #(
   parameter int W = 8
) (
   input  logic         neg,
   input  logic [W-1:0] in_val,
   output logic [W-1:0] out_val
);

   assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-add multiplier for the ALU datapath. Signed operands are
// reduced to magnitudes, multiplied unsigned over WIDTH cycles, then the sign
// is restored in one final cycle. START/BUSY/DONE handshake for stalling.
module seq_mult_unit
   import seq_mult_unit_pkg::*;
#(
   parameter int WIDTH = MULT_W_DEFAULT
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               START,
   input  logic               SIGNED_MODE,
   input  logic [WIDTH-1:0]   DATA1,
   input  logic [WIDTH-1:0]   DATA2,
   output logic [2*WIDTH-1:0] PRODUCT,
   output logic [WIDTH-1:0]   RESULT,
   output logic               OVERFLOW,
   output logic               BUSY,
   output logic               DONE
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               sgn_q, sgn_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   mag1, mag2, addend;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     hi_s;
   logic               ovf_fix;

   // Operand magnitudes: only negative inputs in signed mode are complemented.
   mag_conv #(.W(WIDTH)) u_mag1 (
      .neg     (SIGNED_MODE & DATA1[WIDTH-1]),
      .in_val  (DATA1),
      .out_val (mag1)
   );

   mag_conv #(.W(WIDTH)) u_mag2 (
      .neg     (SIGNED_MODE & DATA2[WIDTH-1]),
      .in_val  (DATA2),
      .out_val (mag2)
   );

   // Sign correction of the unsigned accumulator, mod 2^(2*WIDTH).
   mag_conv #(.W(2*WIDTH)) u_fix (
      .neg     (neg_q),
      .in_val  (acc_q),
      .out_val (prod_fix)
   );

   // One shift-add step: the lower accumulator half holds the remaining
   // multiplier bits, so acc_q[0] is the current multiplier LSB. The extra
   // sum bit catches the carry and shifts straight back into the upper half.
   assign addend = acc_q[0] ? mcand_q : '0;
   assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

   // Signed result fits iff bits [2W-1:W-1] are a pure sign extension.
   assign hi_s    = prod_fix[2*WIDTH-1:WIDTH-1];
   assign ovf_fix = sgn_q ? ~((&hi_s) | (~|hi_s)) : (|prod_fix[2*WIDTH-1:WIDTH]);

   // Next-state and datapath update for the IDLE -> CALC -> SIGN sequence.
   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      sgn_d     = sgn_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               mcand_d = mag1;
               acc_d   = {{WIDTH{1'b0}}, mag2};
               cnt_d   = '0;
               neg_d   = SIGNED_MODE & (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
               sgn_d   = SIGNED_MODE;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_SIGN;
            end
         end
         ST_SIGN: begin
            product_d = prod_fix;
            ovf_d     = ovf_fix;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_CALC) || (state_d == ST_SIGN);
   end

   // State register with synchronous reset; datapath registers are cleared too
   // so an aborted operation leaves nothing visible on the outputs.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (RESET) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         sgn_q     <= 1'b0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         sgn_q     <= sgn_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign PRODUCT  = product_q;
   assign RESULT   = product_q[WIDTH-1:0];
   assign OVERFLOW = ovf_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: a cycle-level behavioural model of
// the WIDTH=8 instance checked every cycle, directed literal cases, random
// traffic, and one WIDTH=16 instance for the wide sign case.
module tb_seq_mult_unit;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          start = 1'b0, sm = 1'b0;
   logic [W-1:0]  d1 = '0, d2 = '0;
   logic [2*W-1:0] prod;
   logic [W-1:0]  res;
   logic          ovf, busy, done;

   logic          start16 = 1'b0, sm16 = 1'b0;
   logic [15:0]   a16 = '0, b16 = '0;
   logic [31:0]   prod16;
   logic [15:0]   res16;
   logic          ovf16, busy16, done16;

   int total = 0;
   int bad   = 0;

   seq_mult_unit #(.WIDTH(W)) dut (
      .CLK(clk), .RESET(rst), .START(start), .SIGNED_MODE(sm),
      .DATA1(d1), .DATA2(d2), .PRODUCT(prod), .RESULT(res),
      .OVERFLOW(ovf), .BUSY(busy), .DONE(done)
   );

   seq_mult_unit #(.WIDTH(16)) dut16 (
      .CLK(clk), .RESET(rst), .START(start16), .SIGNED_MODE(sm16),
      .DATA1(a16), .DATA2(b16), .PRODUCT(prod16), .RESULT(res16),
      .OVERFLOW(ovf16), .BUSY(busy16), .DONE(done16)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference product from plain integer arithmetic on the operand values.
   function automatic void ref_mult(input int w, input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b, output logic [63:0] p, output bit o);
      longint av, bv, pr;
      av = longint'(a) & ((longint'(1) << w) - 1);
      bv = longint'(b) & ((longint'(1) << w) - 1);
      if (sgn && a[w-1]) av = av - (longint'(1) << w);
      if (sgn && b[w-1]) bv = bv - (longint'(1) << w);
      pr = av * bv;
      p  = 64'(pr) & ((64'(1) << (2 * w)) - 1);
      if (sgn) o = (pr < -(longint'(1) << (w - 1))) || (pr >= (longint'(1) << (w - 1)));
      else     o = (pr >= (longint'(1) << w));
   endfunction

   // Cycle-level model: an accepted START keeps the unit busy for W+1 edges,
   // the last of which publishes the result with a one-cycle DONE.
   initial begin : model
      int          rem;
      logic [63:0] m_prod, pend_p;
      bit          m_ovf, pend_o, m_done, valid;
      rem = 0; m_prod = '0; pend_p = '0; m_ovf = 0; pend_o = 0; m_done = 0; valid = 0;
      forever begin
         @(negedge clk);
         if (valid) begin
            check("cyc_product",  64'(prod), m_prod);
            check("cyc_result",   64'(res),  64'(m_prod[W-1:0]));
            check("cyc_overflow", 64'(ovf),  64'(m_ovf));
            check("cyc_busy",     64'(busy), 64'(rem != 0));
            check("cyc_done",     64'(done), 64'(m_done));
         end
         if (rst) begin
            rem = 0; m_prod = '0; m_ovf = 0; m_done = 0; valid = 1;
         end else begin
            m_done = 0;
            if (rem == 0) begin
               if (start) begin
                  ref_mult(W, sm, 32'(d1), 32'(d2), pend_p, pend_o);
                  rem = W + 1;
               end
            end else begin
               rem--;
               if (rem == 0) begin
                  m_prod = pend_p; m_ovf = pend_o; m_done = 1;
               end
            end
         end
      end
   end

   task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; sm = s; d1 = a; d2 = b;
   endtask

   // Wait for DONE (bounded), optionally pulsing a competing START mid-operation.
   task automatic wait_done(input string name, input int inj_at);
      int n = 0;
      bit seen = 0;
      while (n < 40 && !seen) begin
         @(posedge clk); #2;
         n++;
         if (n == 1) start = 1'b0;
         if (inj_at != 0 && n == inj_at) begin
            start = 1'b1; sm = 1'b0; d1 = 8'h11; d2 = 8'h22;
         end
         if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
         if (done) seen = 1;
      end
      check(name, 64'(n), 64'(W + 2));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'h80;
         2:       return 8'h7F;
         3:       return 8'hFF;
         4:       return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin : driver
      int  n;
      bit  seen;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      check("rst_product", 64'(prod), 64'h0);
      check("rst_busy",    64'(busy), 64'h0);
      check("rst_done",    64'(done), 64'h0);
      check("rst16_product", 64'(prod16), 64'h0);

      // -3 * 5 signed
      issue(1'b1, 8'hFD, 8'h05);
      wait_done("lat_neg3x5", 0);
      check("neg3x5_prod", 64'(prod), 64'hFFF1);
      check("neg3x5_res",  64'(res),  64'hF1);
      check("neg3x5_ovf",  64'(ovf),  64'h0);

      // -128 * -128 signed
      issue(1'b1, 8'h80, 8'h80);
      wait_done("lat_m128sq", 0);
      check("m128sq_prod", 64'(prod), 64'h4000);
      check("m128sq_res",  64'(res),  64'h00);
      check("m128sq_ovf",  64'(ovf),  64'h1);

      // 0 * -128 signed
      issue(1'b1, 8'h00, 8'h80);
      wait_done("lat_zero", 0);
      check("zero_prod", 64'(prod), 64'h0);
      check("zero_ovf",  64'(ovf),  64'h0);

      // 255 * 255 unsigned, then -1 * -1 signed
      issue(1'b0, 8'hFF, 8'hFF);
      wait_done("lat_u255", 0);
      check("u255_prod", 64'(prod), 64'hFE01);
      check("u255_ovf",  64'(ovf),  64'h1);
      issue(1'b1, 8'hFF, 8'hFF);
      wait_done("lat_s1", 0);
      check("s1_prod", 64'(prod), 64'h0001);
      check("s1_ovf",  64'(ovf),  64'h0);

      // START during BUSY ignored; then START in the DONE cycle accepted
      issue(1'b1, 8'h07, 8'hF7);
      wait_done("lat_inj", 3);
      check("inj_prod", 64'(prod), 64'hFFC1);
      check("inj_ovf",  64'(ovf),  64'h0);
      issue(1'b0, 8'h10, 8'h10);
      wait_done("lat_b2b", 0);
      check("b2b_prod", 64'(prod), 64'h0100);
      check("b2b_res",  64'(res),  64'h00);
      check("b2b_ovf",  64'(ovf),  64'h1);

      // Reset in mid-CALC aborts the operation
      issue(1'b0, 8'h12, 8'h34);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #2;
         if (i == 1) start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_prod", 64'(prod), 64'h0);
      check("abort_done", 64'(done), 64'h0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #2;
         if (done) seen = 1;
      end
      check("abort_no_done", 64'(seen), 64'h0);
      issue(1'b0, 8'h12, 8'h34);
      wait_done("lat_after_abort", 0);
      check("after_abort_prod", 64'(prod), 64'h03A8);
      check("after_abort_ovf",  64'(ovf),  64'h1);

      // WIDTH=16: -32768 * 1 signed
      start16 = 1'b1; sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h0001;
      n = 0; seen = 0;
      while (n < 60 && !seen) begin
         @(posedge clk); #2;
         n++;
         if (n == 1) start16 = 1'b0;
         if (done16) seen = 1;
      end
      check("w16_lat",  64'(n),      64'd18);
      check("w16_prod", 64'(prod16), 64'hFFFF8000);
      check("w16_res",  64'(res16),  64'h8000);
      check("w16_ovf",  64'(ovf16),  64'h0);

      // Random traffic, including START during BUSY and occasional resets
      repeat (3000) begin
         @(posedge clk); #2;
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 1) == 1);
         sm    = ($urandom_range(0, 1) == 1);
         d1    = pick();
         d2    = pick();
      end
      @(posedge clk); #2;
      rst = 1'b0; start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
